// File: rtl/divider_pkg.sv
// Shared defaults and the channel-index width helper for the multi-channel clock divider.
// Pure declarations: no logic, no latency, no flow control.
package divider_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int unsigned DEFAULT_HALF_DEF = 50000;

  // Index width for a channel select; a single channel still gets a 1-bit port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: active/staged half-period, counter and registered square wave plus rise tick.
// Latency: clk_out/tick change on the edge ending cycle H-1; writes to an enabled channel wait for the next toggle.
// Backpressure: none, every write is accepted (last staged write wins); sync is tied 0 unless DIV_SYNC_EN.
module div_channel import divider_pkg::*; #(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] next_half;
  logic             enabled;
  logic             hit;

  assign enabled   = (half_q != '0);
  assign hit       = enabled && (cnt_q == half_q - CNT_W'(1));
  assign next_half = pend_q ? stage_q : half_q;

  always_comb begin
    half_d  = half_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    if (sync) begin
      // A write in the sync cycle takes precedence over any older staged value.
      half_d = wr_en ? wr_half : next_half;
      pend_d = 1'b0;
      cnt_d  = '0;
      out_d  = 1'b0;
    end else if (enabled) begin
      if (hit) begin
        cnt_d  = '0;
        half_d = next_half;
        pend_d = 1'b0;
        if (next_half == '0) begin
          out_d = 1'b0;
        end else begin
          out_d  = ~out_q;
          tick_d = ~out_q;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // A write landing on the toggle edge stays staged for the following toggle.
      if (wr_en) begin
        stage_d = wr_half;
        pend_d  = 1'b1;
      end
    end else if (wr_en && (wr_half != '0)) begin
      half_d = wr_half;
      cnt_d  = '0;
      out_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q  <= CNT_W'(DEFAULT_HALF);
      stage_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      half_q  <= half_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH runtime-programmable clock dividers with rise ticks; DIV_SYNC_EN adds a global realign port.
// Latency: outputs registered, first rise H cycles after reset release or after a write to a disabled channel.
// Backpressure: none; writes to wr_ch >= NUM_CH are dropped.
module multi_clock_divider import divider_pkg::*; #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]          wr_half,
`ifdef DIV_SYNC_EN
  input  logic                      sync,
`endif
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pend
);

  localparam int CHW = ch_w(NUM_CH);

  logic sync_i;
`ifdef DIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    // Indices past NUM_CH-1 match no channel, so out-of-range writes vanish here.
    assign sel = wr_en && (wr_ch == CHW'(i));

    div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (sel),
      .wr_half (wr_half),
      .sync    (sync_i),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule
